rf_write_arbiter: RTL and testbench

- Shares the single write port of the 8x16-bit register file among three writeback requesters: 0 = ALU result, 1 = memory load, 2 = PC/link update.
- Each requester gets a 2-entry queue. Queues are drained one write per cycle under round-robin arbitration.
- Exports a per-register pending-write scoreboard so the control FSM can stall on read-after-write hazards.

---
 rtl/rf_write_arbiter.sv | 153 +++++++++++++++
 tb/tb_rf_write_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Write-port arbiter for the 8x16 register file: three 2-deep writeback queues,
// round-robin drain of one write per cycle, and a per-register pending-write map.
module rf_write_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NREQ   = 3
) (
  input  logic                     In_clock,
  input  logic                     In_reset,
  input  logic [NREQ-1:0]          In_req_valid,
  input  logic [NREQ*ADDR_W-1:0]   In_req_addr,
  input  logic [NREQ*DATA_W-1:0]   In_req_data,
  output logic [NREQ-1:0]          Out_req_ready,
  input  logic                     In_flush,
  output logic [ADDR_W-1:0]        Out_RF_Write_addr1,
  output logic [DATA_W-1:0]        Out_RF_Write_data1,
  output logic                     Out_RF_Write_en_1,
  output logic [NREQ-1:0]          Out_grant,
  output logic [(2**ADDR_W)-1:0]   Out_busy,
  output logic                     Out_idle
);

  // Queue entry 0 is always the head; a pop shifts entry 1 down.
  logic [NREQ-1:0][1:0][ADDR_W-1:0] qaddr_q, qaddr_d;
  logic [NREQ-1:0][1:0][DATA_W-1:0] qdata_q, qdata_d;
  logic [NREQ-1:0][1:0]             cnt_q, cnt_d;
  logic [1:0]                       last_q, last_d;
  logic [NREQ-1:0]                  grant_q, grant_d;
  logic                             wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]                wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]                wr_data_q, wr_data_d;

  logic [NREQ-1:0]                  nonempty_s;
  logic [NREQ-1:0]                  gnt_s;
  logic [NREQ-1:0]                  push_s;
  logic [(2**ADDR_W)-1:0]           busy_s;

  function automatic logic [2:0] rr_pick(input logic [2:0] cand, input logic [1:0] last);
    logic [2:0] pick;
    pick = 3'b000;
    case (last)
      2'd0: begin
        if (cand[1])      pick = 3'b010;
        else if (cand[2]) pick = 3'b100;
        else if (cand[0]) pick = 3'b001;
        else              pick = 3'b000;
      end
      2'd1: begin
        if (cand[2])      pick = 3'b100;
        else if (cand[0]) pick = 3'b001;
        else if (cand[1]) pick = 3'b010;
        else              pick = 3'b000;
      end
      default: begin
        if (cand[0])      pick = 3'b001;
        else if (cand[1]) pick = 3'b010;
        else if (cand[2]) pick = 3'b100;
        else              pick = 3'b000;
      end
    endcase
    return pick;
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      nonempty_s[i]    = (cnt_q[i] != 2'd0);
      Out_req_ready[i] = ~cnt_q[i][1];
    end
  end

  assign gnt_s  = rr_pick(nonempty_s, last_q);
  assign push_s = In_req_valid & Out_req_ready;

  always_comb begin
    qaddr_d   = qaddr_q;
    qdata_d   = qdata_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    grant_d   = grant_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (In_flush) begin
      cnt_d   = '0;
      wr_en_d = 1'b0;
      grant_d = '0;
    end else begin
      wr_en_d = |gnt_s;
      grant_d = gnt_s;
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_s[i]) begin
          last_d    = 2'(i);
          wr_addr_d = qaddr_q[i][0];
          wr_data_d = qdata_q[i][0];
          qaddr_d[i][0] = qaddr_q[i][1];
          qdata_d[i][0] = qdata_q[i][1];
        end else begin
          qaddr_d[i][0] = qaddr_q[i][0];
        end
        // Push lands behind whatever survives this cycle's pop.
        if (push_s[i]) begin
          qaddr_d[i][cnt_q[i][0] & ~gnt_s[i]] = In_req_addr[i*ADDR_W +: ADDR_W];
          qdata_d[i][cnt_q[i][0] & ~gnt_s[i]] = In_req_data[i*DATA_W +: DATA_W];
        end else begin
          qdata_d[i][1] = qdata_d[i][1];
        end
        cnt_d[i] = cnt_q[i] - {1'b0, gnt_s[i]} + {1'b0, push_s[i]};
      end
    end
  end

  always_comb begin
    busy_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (cnt_q[i] != 2'd0) busy_s[qaddr_q[i][0]] = 1'b1;
      else                  busy_s = busy_s;
      if (cnt_q[i] == 2'd2) busy_s[qaddr_q[i][1]] = 1'b1;
      else                  busy_s = busy_s;
    end
    if (wr_en_q) busy_s[wr_addr_q] = 1'b1;
    else         busy_s = busy_s;
  end

  always_ff @(posedge In_clock) begin
    if (!In_reset) begin
      qaddr_q   <= '0;
      qdata_q   <= '0;
      cnt_q     <= '0;
      last_q    <= 2'd2;
      grant_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      qaddr_q   <= qaddr_d;
      qdata_q   <= qdata_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign Out_RF_Write_addr1 = wr_addr_q;
  assign Out_RF_Write_data1 = wr_data_q;
  assign Out_RF_Write_en_1  = wr_en_q;
  assign Out_grant          = grant_q;
  assign Out_busy           = busy_s;
  assign Out_idle           = (cnt_q == '0) & ~wr_en_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: expected writes queued by the stimulus, drained by a write-port monitor.
module tb_rf_write_arbiter;

  logic        In_clock = 1'b0;
  logic        In_reset;
  logic [2:0]  In_req_valid;
  logic [8:0]  In_req_addr;
  logic [47:0] In_req_data;
  logic [2:0]  Out_req_ready;
  logic        In_flush;
  logic [2:0]  Out_RF_Write_addr1;
  logic [15:0] Out_RF_Write_data1;
  logic        Out_RF_Write_en_1;
  logic [2:0]  Out_grant;
  logic [7:0]  Out_busy;
  logic        Out_idle;

  logic [21:0] sb[$];
  logic [21:0] exp_w;
  int total = 0;
  int bad   = 0;

  always #5 In_clock = ~In_clock;

  rf_write_arbiter dut (
    .In_clock(In_clock), .In_reset(In_reset), .In_req_valid(In_req_valid),
    .In_req_addr(In_req_addr), .In_req_data(In_req_data), .Out_req_ready(Out_req_ready),
    .In_flush(In_flush), .Out_RF_Write_addr1(Out_RF_Write_addr1),
    .Out_RF_Write_data1(Out_RF_Write_data1), .Out_RF_Write_en_1(Out_RF_Write_en_1),
    .Out_grant(Out_grant), .Out_busy(Out_busy), .Out_idle(Out_idle)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge In_clock);
    #1;
  endtask

  task automatic set_req(input logic [2:0] v, input logic [2:0] a0, input logic [2:0] a1,
                         input logic [2:0] a2, input logic [15:0] d0, input logic [15:0] d1,
                         input logic [15:0] d2);
    In_req_valid = v;
    In_req_addr  = {a2, a1, a0};
    In_req_data  = {d2, d1, d0};
  endtask

  task automatic expect_wr(input logic [2:0] g, input logic [2:0] a, input logic [15:0] d);
    sb.push_back({g, a, d});
  endtask

  // Write-port monitor: every presented write must match the next expected one.
  always @(negedge In_clock) begin
    if (Out_RF_Write_en_1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write actual grant=%b addr=%0d data=%h required none",
                 Out_grant, Out_RF_Write_addr1, Out_RF_Write_data1);
      end else begin
        exp_w = sb.pop_front();
        if ({Out_grant, Out_RF_Write_addr1, Out_RF_Write_data1} !== exp_w) begin
          bad++;
          $display("FAIL write actual grant=%b addr=%0d data=%h required grant=%b addr=%0d data=%h",
                   Out_grant, Out_RF_Write_addr1, Out_RF_Write_data1,
                   exp_w[21:19], exp_w[18:16], exp_w[15:0]);
        end
      end
    end else begin
      total++;
      if (Out_grant !== 3'b000) begin
        bad++;
        $display("FAIL idle_grant actual=%b required=000", Out_grant);
      end
    end
  end

  initial begin
    // Reset held with requests asserted
    In_reset = 1'b0;
    In_flush = 1'b0;
    set_req(3'b111, 3'd1, 3'd2, 3'd3, 16'h0001, 16'h0002, 16'h0003);
    tick; tick;
    chk("rst_ready", Out_req_ready, 3'b111);
    chk("rst_en", Out_RF_Write_en_1, 1'b0);
    chk("rst_grant", Out_grant, 3'b000);
    chk("rst_busy", Out_busy, 8'h00);
    chk("rst_idle", Out_idle, 1'b1);
    chk("rst_addr", Out_RF_Write_addr1, 3'd0);
    chk("rst_data", Out_RF_Write_data1, 16'h0000);
    In_reset = 1'b1;
    set_req(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
    tick; tick;
    chk("post_rst_idle", Out_idle, 1'b1);

    // Single write latency
    set_req(3'b010, 3'd0, 3'd5, 3'd0, 16'h0, 16'hBEEF, 16'h0);
    expect_wr(3'b010, 3'd5, 16'hBEEF);
    tick;
    set_req(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
    chk("single_busy_q", Out_busy, 8'h20);
    chk("single_en_q", Out_RF_Write_en_1, 1'b0);
    chk("single_idle_q", Out_idle, 1'b0);
    tick;
    chk("single_en", Out_RF_Write_en_1, 1'b1);
    chk("single_addr", Out_RF_Write_addr1, 3'd5);
    chk("single_data", Out_RF_Write_data1, 16'hBEEF);
    chk("single_grant", Out_grant, 3'b010);
    chk("single_busy_port", Out_busy, 8'h20);
    tick;
    chk("single_busy_done", Out_busy, 8'h00);
    chk("single_idle_done", Out_idle, 1'b1);
    chk("single_en_done", Out_RF_Write_en_1, 1'b0);

    // Reset pulse restores requester 0 priority
    In_reset = 1'b0;
    tick;
    In_reset = 1'b1;

    // Contention and round robin
    set_req(3'b111, 3'd1, 3'd2, 3'd3, 16'h1111, 16'h2222, 16'h3333);
    expect_wr(3'b001, 3'd1, 16'h1111);
    expect_wr(3'b010, 3'd2, 16'h2222);
    expect_wr(3'b100, 3'd3, 16'h3333);
    expect_wr(3'b001, 3'd4, 16'h4444);
    tick;
    chk("rr_busy1", Out_busy, 8'h0E);
    set_req(3'b001, 3'd4, 3'd0, 3'd0, 16'h4444, 16'h0, 16'h0);
    tick;
    set_req(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
    chk("rr_busy2", Out_busy, 8'h1E);
    chk("rr_first_grant", Out_grant, 3'b001);
    tick; tick; tick; tick;
    chk("rr_idle", Out_idle, 1'b1);

    // Full queue back-pressure on requester 2
    set_req(3'b110, 3'd0, 3'd6, 3'd7, 16'h0, 16'h6666, 16'h7001);
    expect_wr(3'b010, 3'd6, 16'h6666);
    expect_wr(3'b100, 3'd7, 16'h7001);
    expect_wr(3'b100, 3'd7, 16'h7002);
    expect_wr(3'b100, 3'd7, 16'h7003);
    tick;
    chk("full_ready1", Out_req_ready, 3'b111);
    set_req(3'b100, 3'd0, 3'd0, 3'd7, 16'h0, 16'h0, 16'h7002);
    tick;
    chk("full_ready2", Out_req_ready, 3'b011);
    chk("full_grant2", Out_grant, 3'b010);
    set_req(3'b100, 3'd0, 3'd0, 3'd7, 16'h0, 16'h0, 16'h7003);
    tick;
    chk("full_ready3", Out_req_ready, 3'b111);
    chk("full_data3", Out_RF_Write_data1, 16'h7001);
    tick;
    set_req(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
    chk("full_data4", Out_RF_Write_data1, 16'h7002);
    tick;
    chk("full_data5", Out_RF_Write_data1, 16'h7003);
    tick;
    chk("hold_en", Out_RF_Write_en_1, 1'b0);
    chk("hold_addr", Out_RF_Write_addr1, 3'd7);
    chk("hold_data", Out_RF_Write_data1, 16'h7003);
    chk("full_idle", Out_idle, 1'b1);

    // Flush mid-stream
    set_req(3'b111, 3'd1, 3'd2, 3'd3, 16'hA001, 16'hB001, 16'hC001);
    expect_wr(3'b001, 3'd1, 16'hA001);
    tick;
    set_req(3'b110, 3'd0, 3'd5, 3'd6, 16'h0, 16'hB002, 16'hC002);
    tick;
    chk("flush_busy_pre", Out_busy, 8'h6E);
    chk("flush_en_pre", Out_RF_Write_en_1, 1'b1);
    In_flush = 1'b1;
    set_req(3'b001, 3'd7, 3'd0, 3'd0, 16'hDEAD, 16'h0, 16'h0);
    tick;
    In_flush = 1'b0;
    set_req(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
    chk("flush_en", Out_RF_Write_en_1, 1'b0);
    chk("flush_grant", Out_grant, 3'b000);
    chk("flush_busy", Out_busy, 8'h00);
    chk("flush_idle", Out_idle, 1'b1);
    chk("flush_ready", Out_req_ready, 3'b111);
    chk("flush_addr_hold", Out_RF_Write_addr1, 3'd1);
    chk("flush_data_hold", Out_RF_Write_data1, 16'hA001);
    tick; tick;
    chk("flush_idle2", Out_idle, 1'b1);

    // Pointer kept across flush, then reset under load
    set_req(3'b111, 3'd1, 3'd2, 3'd3, 16'h0011, 16'h1011, 16'h2011);
    expect_wr(3'b010, 3'd2, 16'h1011);
    expect_wr(3'b100, 3'd3, 16'h2011);
    tick;
    set_req(3'b111, 3'd1, 3'd2, 3'd3, 16'h0012, 16'h1012, 16'h2012);
    tick;
    chk("load_grant1", Out_grant, 3'b010);
    chk("load_ready1", Out_req_ready, 3'b010);
    set_req(3'b111, 3'd1, 3'd2, 3'd3, 16'h0013, 16'h1013, 16'h2013);
    tick;
    chk("load_grant2", Out_grant, 3'b100);
    chk("load_ready2", Out_req_ready, 3'b100);
    In_reset = 1'b0;
    tick;
    In_reset = 1'b1;
    chk("mid_rst_en", Out_RF_Write_en_1, 1'b0);
    chk("mid_rst_busy", Out_busy, 8'h00);
    chk("mid_rst_ready", Out_req_ready, 3'b111);
    chk("mid_rst_grant", Out_grant, 3'b000);
    chk("mid_rst_idle", Out_idle, 1'b1);
    chk("mid_rst_addr", Out_RF_Write_addr1, 3'd0);
    set_req(3'b111, 3'd1, 3'd2, 3'd3, 16'h0015, 16'h1015, 16'h2015);
    expect_wr(3'b001, 3'd1, 16'h0015);
    expect_wr(3'b010, 3'd2, 16'h1015);
    expect_wr(3'b100, 3'd3, 16'h2015);
    tick;
    set_req(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
    tick;
    chk("post_rst_grant", Out_grant, 3'b001);
    tick; tick; tick;
    chk("final_idle", Out_idle, 1'b1);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
